bus_mem_emu: RTL

- Synthesizable, parametrised memory and clock emulator for the 6502 core's external bus.
- Derives the CPU phase clock (clk) and a delayed data clock (dclk) from the fast clock clk4.
- Serves vector, ROM and RAM regions on a single-strobe access schedule.
- ROM and vectors are preloadable; ROM is optionally write-protected. Used in system sim and FPGA bring-up in place of bench-only memory models.

---
 rtl/bus_mem_pkg.sv | 23 ++
 rtl/bus_mem_emu_if.sv | 11 +
 rtl/bus_clk_gen.sv | 51 +++++
 rtl/bus_mem_emu.sv | 119 +++++++++++
 4 files changed

// File: rtl/bus_mem_pkg.sv
// Shared constants, region type and address decode for the bus memory emulator.
package bus_mem_pkg;

  localparam logic [15:0] VEC_BASE = 16'hFFFA;

  typedef enum logic [1:0] {
    REG_VEC,
    REG_ROM,
    REG_RAM
  } region_t;

  // Vectors sit on top of the map and take priority over everything else.
  function automatic region_t decode_region(input logic [15:0] addr, input int unsigned rom_size);
    if (addr >= VEC_BASE) begin
      return REG_VEC;
    end else if ({16'd0, addr} < rom_size) begin
      return REG_ROM;
    end else begin
      return REG_RAM;
    end
  endfunction

endpackage

// File: rtl/bus_mem_emu_if.sv
// CPU-side bus of the memory emulator: address/control from the CPU, read data back.
interface bus_mem_emu_if;
  logic [15:0] addr;
  logic        rw;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        oe;

  modport master (output addr, rw, wdata, input rdata, oe);
  modport slave  (input addr, rw, wdata, output rdata, oe);
endinterface

// File: rtl/bus_clk_gen.sv
// Phase counter, CPU phase clock, delayed data clock and the single bus-sample strobe.
// clk/dclk are registered; strobe is combinational from the phase counter, no backpressure.
module bus_clk_gen #(
  parameter int DIV       = 4,
  parameter int DCLK_DLY  = 2,
  parameter int SAMPLE_PH = 1
) (
  input  logic clk4,
  input  logic n_reset,
  output logic o_clk,
  output logic o_dclk,
  output logic o_strobe
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PH_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF   = PW'(DIV / 2);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PH);

  logic [PW-1:0]       r_ph;
  logic                r_clk;
  logic [DCLK_DLY-1:0] r_dly;

  always_ff @(posedge clk4 or negedge n_reset) begin
    if (!n_reset) begin
      r_ph  <= '0;
      r_clk <= 1'b0;
    end else begin
      r_ph  <= (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
      r_clk <= (r_ph < PH_HALF);
    end
  end

  if (DCLK_DLY == 1) begin : g_dly1
    always_ff @(posedge clk4 or negedge n_reset) begin
      if (!n_reset) r_dly <= '0;
      else          r_dly <= r_clk;
    end
  end else begin : g_dlyn
    always_ff @(posedge clk4 or negedge n_reset) begin
      if (!n_reset) r_dly <= '0;
      else          r_dly <= {r_dly[DCLK_DLY-2:0], r_clk};
    end
  end

  assign o_clk  = r_clk;
  assign o_dclk = r_dly[DCLK_DLY-1];
  // Gated by reset so an access caught by reset never lands, whatever SAMPLE_PH is.
  assign o_strobe = n_reset && (r_ph == PH_SAMPLE);

endmodule

// File: rtl/bus_mem_emu.sv
// Clock and memory emulator for the 6502 bus: vectors, ROM and mirrored RAM on one strobe per clk.
// rdata is registered one clk4 after the strobe; preload writes ROM/vectors on any clk4, no backpressure.
module bus_mem_emu
  import bus_mem_pkg::*;
#(
  parameter int          DIV       = 4,
  parameter int          DCLK_DLY  = 2,
  parameter int          SAMPLE_PH = 1,
  parameter int unsigned ROM_SIZE  = 72,
  parameter bit          ROM_WP    = 1'b0,
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] NMI_VEC   = 16'h3412,
  parameter logic [15:0] RST_VEC   = 16'h0001,
  parameter logic [15:0] IRQ_VEC   = 16'h0000
) (
  input  logic          clk4,
  input  logic          n_reset,
  output logic          clk,
  output logic          dclk,
  bus_mem_emu_if.slave  bus,
  input  logic          ld_we,
  input  logic [15:0]   ld_addr,
  input  logic [7:0]    ld_data,
  output logic          wp_viol
);

  localparam int ROM_AW = (ROM_SIZE > 1) ? $clog2(ROM_SIZE) : 1;

  logic [7:0] r_vec [0:5];
  logic [7:0] r_rom [0:ROM_SIZE-1];
  logic [7:0] r_ram [0:(1<<RAM_AW)-1];
  logic [7:0] r_rdata;
  logic       r_wp_viol;

  logic       w_strobe;
  region_t    w_bus_reg;
  region_t    w_ld_reg;
  logic [2:0] w_bus_vec_idx;
  logic [2:0] w_ld_vec_idx;
  logic       w_bus_we;
  logic       w_blocked;
  logic       w_collide;
  logic [7:0] w_rd_byte;

  bus_clk_gen #(
    .DIV       (DIV),
    .DCLK_DLY  (DCLK_DLY),
    .SAMPLE_PH (SAMPLE_PH)
  ) u_clk_gen (
    .clk4     (clk4),
    .n_reset  (n_reset),
    .o_clk    (clk),
    .o_dclk   (dclk),
    .o_strobe (w_strobe)
  );

  assign w_bus_reg     = decode_region(bus.addr, ROM_SIZE);
  assign w_ld_reg      = decode_region(ld_addr, ROM_SIZE);
  assign w_bus_vec_idx = bus.addr[2:0] - VEC_BASE[2:0];
  assign w_ld_vec_idx  = ld_addr[2:0] - VEC_BASE[2:0];

  assign w_bus_we  = w_strobe && !bus.rw;
  assign w_blocked = (w_bus_reg == REG_VEC) || ((w_bus_reg == REG_ROM) && ROM_WP);
  // A preload to the very byte the bus is writing wins and silences the violation.
  assign w_collide = ld_we && (ld_addr == bus.addr) && (w_ld_reg != REG_RAM);

  always_comb begin
    w_rd_byte = '0;
    case (w_bus_reg)
      REG_VEC: w_rd_byte = r_vec[w_bus_vec_idx];
      REG_ROM: w_rd_byte = r_rom[bus.addr[ROM_AW-1:0]];
      default: w_rd_byte = r_ram[bus.addr[RAM_AW-1:0]];
    endcase
  end

  always_ff @(posedge clk4 or negedge n_reset) begin
    if (!n_reset) begin
      r_vec[0] <= NMI_VEC[7:0];
      r_vec[1] <= NMI_VEC[15:8];
      r_vec[2] <= RST_VEC[7:0];
      r_vec[3] <= RST_VEC[15:8];
      r_vec[4] <= IRQ_VEC[7:0];
      r_vec[5] <= IRQ_VEC[15:8];
    end else if (ld_we && (w_ld_reg == REG_VEC)) begin
      r_vec[w_ld_vec_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk4) begin
    if (w_bus_we && (w_bus_reg == REG_ROM) && !ROM_WP && !w_collide) begin
      r_rom[bus.addr[ROM_AW-1:0]] <= bus.wdata;
    end
    if (ld_we && (w_ld_reg == REG_ROM)) begin
      r_rom[ld_addr[ROM_AW-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk4) begin
    if (w_bus_we && (w_bus_reg == REG_RAM)) begin
      r_ram[bus.addr[RAM_AW-1:0]] <= bus.wdata;
    end
  end

  // Arrays update with non-blocking writes, so a same-strobe read sees the old byte.
  always_ff @(posedge clk4 or negedge n_reset) begin
    if (!n_reset) begin
      r_rdata   <= '0;
      r_wp_viol <= 1'b0;
    end else begin
      if (w_strobe) r_rdata <= w_rd_byte;
      r_wp_viol <= w_bus_we && w_blocked && !w_collide;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.oe    = bus.rw;
  assign wp_viol   = r_wp_viol;

endmodule
